// File: rtl/addroundkey_ks.sv
// AES-128 AddRoundKey stage with an iterative key schedule.
// A key load expands 11 round keys, one per cycle, into local storage.
// Each data beat is XORed with the stored round key it selects, one cycle later.

// Forward S-box: multiplicative inverse in GF(2^8), followed by the affine map.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // Raise a to the power 254 (its inverse, and 0 for a == 0), then apply the affine map.
  always_comb begin
    inv = a;
    for (int i = 0; i < 6; i++) inv = gmul(gmul(inv, inv), a);
    inv = gmul(inv, inv);
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module addroundkey_ks #(
  parameter int WORD = 32,
  parameter int NB   = 4,
  parameter int NR   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_key_valid,
  input  logic [WORD*NB-1:0] i_key,
  output logic               o_key_ready,
  input  logic               i_valid,
  input  logic [3:0]         i_round,
  input  logic [WORD*NB-1:0] i_block,
  output logic               o_valid,
  output logic [WORD*NB-1:0] o_block,
  output logic               o_err
);
  localparam int BW     = WORD * NB;
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t               state, state_n;
  logic [3:0]           cnt;
  logic [NR:0][BW-1:0]  rk;
  logic [BW-1:0]        prev, nxt;
  logic [WORD-1:0]      w0, w1, w2, w3, temp;
  logic [NB-1:0][7:0]   rot, sub;
  logic [7:0]           rcon;
  logic                 accept;
  logic [STAGES:0]      vld_pipe;

  // Previous round key and its word split.
  always_comb begin
    prev = rk[cnt - 4'd1];
    w0   = prev[BW-1 -: WORD];
    w1   = prev[BW-1-WORD -: WORD];
    w2   = prev[BW-1-2*WORD -: WORD];
    w3   = prev[WORD-1:0];
    rot  = {w3[23:0], w3[31:24]};
  end

  // SubWord: one S-box per byte of the rotated word.
  for (genvar j = 0; j < NB; j++) begin : g_sub
    sbox u_sbox (.a(rot[j]), .y(sub[j]));
  end

  // Round constant for the round key being produced.
  always_comb begin
    case (cnt)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Next round key from the previous one; the word chain runs through n0..n3.
  always_comb begin
    logic [WORD-1:0] n0, n1, n2, n3;
    temp = sub ^ {rcon, 24'h0};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    nxt  = {n0, n1, n2, n3};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state: a key load restarts expansion from any state.
  always_comb begin
    state_n = state;
    if (i_key_valid)                               state_n = EXPAND;
    else if (state == EXPAND && cnt == 4'(NR))     state_n = READY;
  end

  assign o_key_ready = (state == READY);

  // Key storage and round counter; written only on a load or while expanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rk  <= '0;
      cnt <= '0;
    end else if (i_key_valid) begin
      rk[0] <= i_key;
      cnt   <= 4'd1;
    end else if (state == EXPAND && cnt >= 4'd1 && cnt <= 4'(NR)) begin
      rk[cnt] <= nxt;
      cnt     <= cnt + 4'd1;
    end
  end

  // A beat is taken only with a complete schedule, no competing load and a legal round.
  assign accept      = i_valid && state == READY && !i_key_valid && i_round <= 4'(NR);
  assign vld_pipe[0] = accept;
  assign o_valid     = vld_pipe[STAGES];

  // Registered AddRoundKey; o_block holds across idle or rejected beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe[STAGES:1] <= '0;
      o_block            <= '0;
      o_err              <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      o_err              <= i_valid && !accept;
      if (accept) o_block <= i_block ^ rk[i_round];
    end
  end
endmodule
